calc_op_scheduler: RTL and testbench

Sequencer and round-robin arbiter that shares one 2-bit arithmetic datapath (multiply / add / subtract, 3-bit result) between two requesters. It accepts operand/opcode requests over valid/ready handshakes and drives the datapath's one-hot operation select for a programmable number of cycles. It then captures the 3-bit result and returns it, tagged with the requester ID, over a valid/ready response channel. It sits between the tile's input-decode logic and the shared arithmetic datapath/7-segment output path.

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/calc_rr_arb2.sv | 40 ++++
 rtl/calc_op_scheduler.sv | 162 ++++++++++++++++
 tb/tb_calc_op_scheduler.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calc operation scheduler.
//   op_t     : request opcode (mul / add / sub / illegal)
//   state_t  : scheduler FSM states
//   SEL_*    : one-hot datapath select encodings (all-zero = idle)
//   DP_LAT_* : legal range of the datapath latency parameter
//   sel_decode() : opcode to one-hot select
package calc_pkg;

   typedef enum logic [1:0] {
      OP_MUL = 2'b00,
      OP_ADD = 2'b01,
      OP_SUB = 2'b10,
      OP_ILL = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   localparam logic [2:0] SEL_IDLE = 3'b000;
   localparam logic [2:0] SEL_MUL  = 3'b001;
   localparam logic [2:0] SEL_ADD  = 3'b010;
   localparam logic [2:0] SEL_SUB  = 3'b100;

   localparam int unsigned DP_LAT_MIN = 1;
   localparam int unsigned DP_LAT_MAX = 4;

   function automatic logic [2:0] sel_decode(input op_t op);
      logic [2:0] sel;
      case (op)
         OP_MUL:  sel = SEL_MUL;
         OP_ADD:  sel = SEL_ADD;
         OP_SUB:  sel = SEL_SUB;
         default: sel = SEL_IDLE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/calc_rr_arb2.sv
// calc_rr_arb2: two-requester round-robin arbiter.
//   clk, rst  : clock, synchronous active-high reset
//   valid[1:0]: request valid per requester
//   fire      : a grant was consumed this cycle; advances the pointer
//   grant[1:0]: one-hot grant (zero when nothing is valid)
//   grant_id  : index of the granted requester
// The last-grant pointer resets to 1 so requester 0 wins the first tie.
module calc_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       fire,
   output logic [1:0] grant,
   output logic       grant_id
);

   logic last;

   always_comb begin
      grant_id = 1'b0;
      case (valid)
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last;
         default: grant_id = 1'b0;
      endcase
      grant = '0;
      if (valid != 2'b00) begin
         grant = grant_id ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last <= 1'b1;
      end else if (fire) begin
         last <= grant_id;
      end
   end

endmodule

// File: rtl/calc_op_scheduler.sv
// calc_op_scheduler: shares one 2-bit mul/add/sub datapath between two
// requesters. Accepts requests (round-robin), drives the one-hot dp_sel for
// DP_LAT cycles, captures dp_result and returns it tagged with the requester id.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready[1:0] : request handshake per requester
//   req{0,1}_{a,b,op}        : operands and opcode (00 mul, 01 add, 10 sub, 11 illegal)
//   dp_a, dp_b, dp_sel       : datapath drive (zero outside EXEC)
//   dp_result                : datapath result, captured in the last EXEC cycle
//   rsp_valid/rsp_ready      : response handshake
//   rsp_id, rsp_data         : requester tag and result
//   rsp_err                  : illegal op or sub underflow (only with CALC_SCHED_ERR_EN)
//   busy                     : FSM not in IDLE
// Optional feature macro: CALC_SCHED_ERR_EN.
module calc_op_scheduler
   import calc_pkg::*;
#(
   parameter int unsigned DP_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   input  logic [1:0] req0_a,
   input  logic [1:0] req0_b,
   input  logic [1:0] req0_op,
   input  logic [1:0] req1_a,
   input  logic [1:0] req1_b,
   input  logic [1:0] req1_op,
   output logic [1:0] dp_a,
   output logic [1:0] dp_b,
   output logic [2:0] dp_sel,
   input  logic [2:0] dp_result,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [2:0] rsp_data,
`ifdef CALC_SCHED_ERR_EN
   output logic       rsp_err,
`endif
   output logic       busy
);

   localparam logic [1:0] CNT_LAST = 2'(DP_LAT - 1);

   state_t     state, state_n;
   logic [1:0] grant;
   logic       grant_id;
   logic       fire;
   logic [1:0] sel_a, sel_b;
   op_t        sel_op;
   logic [1:0] a_q, b_q;
   op_t        op_q;
   logic       id_q;
   logic [1:0] cnt;
   logic       cnt_last;
   logic [2:0] data_q;

   calc_rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .valid    (req_valid),
      .fire     (fire),
      .grant    (grant),
      .grant_id (grant_id)
   );

   // Fire derived from the arbiter grant directly, not from req_ready, so the
   // FSM comb block does not feed back into itself.
   assign fire     = (state == IDLE) && ((req_valid & grant) != 2'b00);
   assign sel_a    = grant_id ? req1_a : req0_a;
   assign sel_b    = grant_id ? req1_b : req0_b;
   assign sel_op   = op_t'(grant_id ? req1_op : req0_op);
   assign cnt_last = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      req_ready = '0;
      dp_sel    = SEL_IDLE;
      dp_a      = '0;
      dp_b      = '0;
      rsp_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            req_ready = grant;
            if (fire) begin
               state_n = (sel_op == OP_ILL) ? RESP : EXEC;
            end
         end
         EXEC: begin
            dp_a   = a_q;
            dp_b   = b_q;
            dp_sel = sel_decode(op_q);
            if (cnt_last) begin
               state_n = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_MUL;
         id_q   <= 1'b0;
         cnt    <= '0;
         data_q <= '0;
      end else begin
         if (fire) begin
            a_q  <= sel_a;
            b_q  <= sel_b;
            op_q <= sel_op;
            id_q <= grant_id;
            if (sel_op == OP_ILL) begin
               data_q <= '0;
            end
         end
         if (state == EXEC) begin
            cnt <= cnt_last ? 2'b00 : cnt + 2'd1;
            if (cnt_last) begin
               data_q <= dp_result;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

`ifdef CALC_SCHED_ERR_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (fire) begin
         err_q <= (sel_op == OP_ILL) || ((sel_op == OP_SUB) && (sel_a < sel_b));
      end
   end

   assign rsp_err = err_q;
`endif

   assign rsp_id   = id_q;
   assign rsp_data = data_q;

endmodule

// File: tb/tb_calc_op_scheduler.sv
// Self-checking bench for calc_op_scheduler: one instance with DP_LAT=1 and
// one with DP_LAT=3, each driven by a behavioural datapath model.
module tb_calc_op_scheduler;

   typedef struct packed {
      logic       id;
      logic [2:0] data;
      logic       err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // DP_LAT = 1 instance
   logic [1:0] req_valid = '0;
   logic [1:0] req_ready;
   logic [1:0] a0 = '0, b0 = '0, op0 = '0, a1 = '0, b1 = '0, op1 = '0;
   logic [1:0] dp_a, dp_b;
   logic [2:0] dp_sel, dp_result;
   logic       rsp_valid, rsp_id, busy;
   logic       rsp_ready = 1'b1;
   logic [2:0] rsp_data;
`ifdef CALC_SCHED_ERR_EN
   logic       rsp_err;
`endif

   // DP_LAT = 3 instance
   logic [1:0] req_valid_3 = '0;
   logic [1:0] req_ready_3;
   logic [1:0] a0_3 = '0, b0_3 = '0, op0_3 = '0, a1_3 = '0, b1_3 = '0, op1_3 = '0;
   logic [1:0] dp_a_3, dp_b_3;
   logic [2:0] dp_sel_3, dp_result_3;
   logic       rsp_valid_3, rsp_id_3, busy_3;
   logic       rsp_ready_3 = 1'b1;
   logic [2:0] rsp_data_3;
`ifdef CALC_SCHED_ERR_EN
   logic       rsp_err_3;
`endif

   always #5 clk = ~clk;

   calc_op_scheduler #(.DP_LAT(1)) u1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(a0), .req0_b(b0), .req0_op(op0), .req1_a(a1), .req1_b(b1), .req1_op(op1),
      .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_result(dp_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
`ifdef CALC_SCHED_ERR_EN
      .rsp_err(rsp_err),
`endif
      .busy(busy)
   );

   calc_op_scheduler #(.DP_LAT(3)) u3 (
      .clk(clk), .rst(rst), .req_valid(req_valid_3), .req_ready(req_ready_3),
      .req0_a(a0_3), .req0_b(b0_3), .req0_op(op0_3), .req1_a(a1_3), .req1_b(b1_3), .req1_op(op1_3),
      .dp_a(dp_a_3), .dp_b(dp_b_3), .dp_sel(dp_sel_3), .dp_result(dp_result_3),
      .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_id(rsp_id_3), .rsp_data(rsp_data_3),
`ifdef CALC_SCHED_ERR_EN
      .rsp_err(rsp_err_3),
`endif
      .busy(busy_3)
   );

   // 3-bit wrapping arithmetic of the shared datapath
   function automatic logic [2:0] calc(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
      logic [2:0] xa, xb, r;
      xa = {1'b0, a};
      xb = {1'b0, b};
      case (op)
         2'b00:   r = xa * xb;
         2'b01:   r = xa + xb;
         2'b10:   r = xa - xb;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   function automatic logic calc_err(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
      return (op == 2'b11) || ((op == 2'b10) && (a < b));
   endfunction

   // datapath models: idle select returns zero so a mistimed capture shows up
   always_comb begin
      case (dp_sel)
         3'b001:  dp_result = calc(2'b00, dp_a, dp_b);
         3'b010:  dp_result = calc(2'b01, dp_a, dp_b);
         3'b100:  dp_result = calc(2'b10, dp_a, dp_b);
         default: dp_result = 3'b000;
      endcase
   end

   always_comb begin
      case (dp_sel_3)
         3'b001:  dp_result_3 = calc(2'b00, dp_a_3, dp_b_3);
         3'b010:  dp_result_3 = calc(2'b01, dp_a_3, dp_b_3);
         3'b100:  dp_result_3 = calc(2'b10, dp_a_3, dp_b_3);
         default: dp_result_3 = 3'b000;
      endcase
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if ({busy, rsp_valid, rsp_id, rsp_data, dp_sel, dp_a, dp_b, req_ready} !== 15'd0) begin
         failures++;
         $display("FAIL reset_u1 got=%h expected=0", {busy, rsp_valid, rsp_id, rsp_data, dp_sel, dp_a, dp_b, req_ready});
      end
      checks++;
      if ({busy_3, rsp_valid_3, rsp_id_3, rsp_data_3, dp_sel_3, dp_a_3, dp_b_3, req_ready_3} !== 15'd0) begin
         failures++;
         $display("FAIL reset_u3 got=%h expected=0", {busy_3, rsp_valid_3, rsp_id_3, rsp_data_3, dp_sel_3, dp_a_3, dp_b_3, req_ready_3});
      end
`ifdef CALC_SCHED_ERR_EN
      checks++;
      if (rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_err got=%b expected=0", rsp_err);
      end
`endif
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single();
      a0 = 2'd3; b0 = 2'd2; op0 = 2'b00; req_valid = 2'b01;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL single_ready got=%b expected=01", req_ready);
      end
      sb.push_back(exp_t'{id: 1'b0, data: 3'b110, err: 1'b0});
      @(posedge clk); #1;
      req_valid = 2'b00;
      #1;
      checks++;
      if ({dp_sel, dp_a, dp_b, rsp_valid, busy} !== {3'b001, 2'd3, 2'd2, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL single_exec got sel=%b a=%0d b=%0d rv=%b busy=%b expected sel=001 a=3 b=2 rv=0 busy=1",
                  dp_sel, dp_a, dp_b, rsp_valid, busy);
      end
      @(posedge clk); #2;
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, dp_sel} !== {1'b1, e.id, e.data, 3'b000}) begin
         failures++;
         $display("FAIL single_rsp got rv=%b id=%b data=%b sel=%b expected rv=1 id=%b data=%b sel=000",
                  rsp_valid, rsp_id, rsp_data, dp_sel, e.id, e.data);
      end
      @(posedge clk); #2;
      checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
         failures++;
         $display("FAIL single_idle got busy=%b rv=%b expected 0 0", busy, rsp_valid);
      end
   endtask

   task automatic test_contention();
      logic [2:0] exp_order;
      int         grants;
      int         got;
      logic       prev_rsp;
      exp_order = 3'b010;
      grants    = 0;
      got       = 0;
      prev_rsp  = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      a0 = 2'd1; b0 = 2'd1; op0 = 2'b01;
      a1 = 2'd2; b1 = 2'd3; op1 = 2'b00;
      req_valid = 2'b11;
      for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
         #1;
         checks++;
         if (req_ready === 2'b11) begin
            failures++;
            $display("FAIL contention_both_ready got=%b expected one-hot or 00", req_ready);
         end
         if (prev_rsp && grants < 3) begin
            checks++;
            if (req_ready === 2'b00) begin
               failures++;
               $display("FAIL back_to_back got ready=%b expected a grant in the cycle after rsp handshake", req_ready);
            end
         end
         if (req_ready !== 2'b00 && grants < 3) begin
            checks++;
            if (req_ready[1] !== exp_order[grants]) begin
               failures++;
               $display("FAIL contention_order grant%0d got=%b expected=%b", grants, req_ready[1], exp_order[grants]);
            end
            if (req_ready[1])
               sb.push_back(exp_t'{id: 1'b1, data: calc(op1, a1, b1), err: calc_err(op1, a1, b1)});
            else
               sb.push_back(exp_t'{id: 1'b0, data: calc(op0, a0, b0), err: calc_err(op0, a0, b0)});
            grants++;
         end
         if (rsp_valid === 1'b1) begin
            e = sb.pop_front();
            got++;
            checks++;
            if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
               failures++;
               $display("FAIL contention_rsp%0d got id=%b data=%b expected id=%b data=%b", got, rsp_id, rsp_data, e.id, e.data);
            end
         end
         prev_rsp = rsp_valid & rsp_ready;
         @(posedge clk); #1;
         if (grants == 3) req_valid = 2'b00;
      end
      checks++;
      if (got != 3) begin
         failures++;
         $display("FAIL contention_timeout got=%0d responses expected=3", got);
      end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      a1 = 2'd2; b1 = 2'd1; op1 = 2'b10; req_valid = 2'b10;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         failures++;
         $display("FAIL bp_ready got=%b expected=10", req_ready);
      end
      sb.push_back(exp_t'{id: 1'b1, data: calc(op1, a1, b1), err: calc_err(op1, a1, b1)});
      @(posedge clk); #1;
      a0 = 2'd1; b0 = 2'd2; op0 = 2'b01; req_valid = 2'b01;
      @(posedge clk); #1;
      @(posedge clk); #1;
      e = sb.pop_front();
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if ({rsp_valid, rsp_id, rsp_data, req_ready, busy} !== {1'b1, e.id, e.data, 2'b00, 1'b1}) begin
            failures++;
            $display("FAIL bp_hold cyc%0d got rv=%b id=%b data=%b ready=%b busy=%b expected rv=1 id=%b data=%b ready=00 busy=1",
                     i, rsp_valid, rsp_id, rsp_data, req_ready, busy, e.id, e.data);
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #2;
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL bp_next_ready got=%b expected=01", req_ready);
      end
      sb.push_back(exp_t'{id: 1'b0, data: calc(op0, a0, b0), err: calc_err(op0, a0, b0)});
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(posedge clk); #2;
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin
         failures++;
         $display("FAIL bp_next_rsp got rv=%b id=%b data=%b expected rv=1 id=%b data=%b", rsp_valid, rsp_id, rsp_data, e.id, e.data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_illegal();
      a1 = 2'd3; b1 = 2'd3; op1 = 2'b11; req_valid = 2'b10;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         failures++;
         $display("FAIL ill_ready got=%b expected=10", req_ready);
      end
      sb.push_back(exp_t'{id: 1'b1, data: 3'b000, err: 1'b1});
      @(posedge clk); #1;
      req_valid = 2'b00;
      #1;
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, dp_sel, dp_a, dp_b} !== {1'b1, e.id, e.data, 3'b000, 2'b00, 2'b00}) begin
         failures++;
         $display("FAIL ill_rsp got rv=%b id=%b data=%b sel=%b a=%0d b=%0d expected rv=1 id=1 data=000 sel=000 a=0 b=0",
                  rsp_valid, rsp_id, rsp_data, dp_sel, dp_a, dp_b);
      end
`ifdef CALC_SCHED_ERR_EN
      checks++;
      if (rsp_err !== e.err) begin
         failures++;
         $display("FAIL ill_err got=%b expected=%b", rsp_err, e.err);
      end
`endif
      @(posedge clk); #2;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL ill_idle got busy=%b expected=0", busy);
      end
   endtask

   task automatic test_lat3_sub();
      int sel_cnt;
      int any_cnt;
      int cyc;
      sel_cnt = 0;
      any_cnt = 0;
      a0_3 = 2'd1; b0_3 = 2'd2; op0_3 = 2'b10; req_valid_3 = 2'b01;
      #1;
      checks++;
      if (req_ready_3 !== 2'b01) begin
         failures++;
         $display("FAIL lat3_ready got=%b expected=01", req_ready_3);
      end
      sb.push_back(exp_t'{id: 1'b0, data: calc(op0_3, a0_3, b0_3), err: calc_err(op0_3, a0_3, b0_3)});
      @(posedge clk); #1;
      req_valid_3 = 2'b00;
      for (cyc = 1; cyc <= 10; cyc++) begin
         #1;
         if (rsp_valid_3 === 1'b1) break;
         if (dp_sel_3 === 3'b100) sel_cnt++;
         if (dp_sel_3 !== 3'b000) any_cnt++;
         @(posedge clk); #1;
      end
      checks++;
      if (sel_cnt != 3 || any_cnt != 3) begin
         failures++;
         $display("FAIL lat3_sel_cycles got sub=%0d any=%0d expected 3 3", sel_cnt, any_cnt);
      end
      checks++;
      if (cyc != 4) begin
         failures++;
         $display("FAIL lat3_latency got=%0d expected=4", cyc);
      end
      e = sb.pop_front();
      checks++;
      if ({rsp_valid_3, rsp_id_3, rsp_data_3, dp_sel_3} !== {1'b1, e.id, e.data, 3'b000}) begin
         failures++;
         $display("FAIL lat3_rsp got rv=%b id=%b data=%b sel=%b expected rv=1 id=%b data=%b sel=000",
                  rsp_valid_3, rsp_id_3, rsp_data_3, dp_sel_3, e.id, e.data);
      end
`ifdef CALC_SCHED_ERR_EN
      checks++;
      if (rsp_err_3 !== e.err) begin
         failures++;
         $display("FAIL lat3_err got=%b expected=%b", rsp_err_3, e.err);
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_exec();
      logic seen;
      seen = 1'b0;
      a0_3 = 2'd1; b0_3 = 2'd1; op0_3 = 2'b01;
      a1_3 = 2'd1; b1_3 = 2'd1; op1_3 = 2'b01;
      req_valid_3 = 2'b11;
      #1;
      checks++;
      if (req_ready_3 !== 2'b10) begin
         failures++;
         $display("FAIL rst_mid_grant got=%b expected=10", req_ready_3);
      end
      @(posedge clk); #2;
      checks++;
      if (dp_sel_3 !== 3'b010) begin
         failures++;
         $display("FAIL rst_mid_exec got sel=%b expected=010", dp_sel_3);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({busy_3, dp_sel_3, rsp_valid_3} !== 5'b00000) begin
         failures++;
         $display("FAIL rst_mid_idle got busy=%b sel=%b rv=%b expected 0 000 0", busy_3, dp_sel_3, rsp_valid_3);
      end
      checks++;
      if (req_ready_3 !== 2'b01) begin
         failures++;
         $display("FAIL rst_mid_tie got=%b expected=01", req_ready_3);
      end
      req_valid_3 = 2'b00;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #2;
         if (rsp_valid_3 !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_discard got a response after reset expected none");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_illegal();
      test_lat3_sub();
      test_reset_mid_exec();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
